// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and its sink.
// The arbiter uses the slave modport; whoever drives the requests and the sink ready uses master.
interface mux2_rr_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              out_ready;
    logic              sel;
    logic              gnt0;
    logic              gnt1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              ack0;
    logic              ack1;

    modport master (
        output req0, data0, req1, data1, out_ready,
        input  sel, gnt0, gnt1, out_valid, out_data, ack0, ack1
    );

    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output sel, gnt0, gnt1, out_valid, out_data, ack0, ack1
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 bit-wise mux with a valid/ready sink.
// Grants are burst-capped at MAX_BURST accepted beats so neither side can starve the other.
module mux2_rr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux2_rr_arbiter_if.slave     bus
);

    localparam logic [7:0] LastBeat = 8'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e     r_state;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_sel;
    logic       r_last;
    logic [7:0] r_cnt;

    logic w_ack0;
    logic w_ack1;
    logic w_final;

    assign w_ack0  = (r_state == StOwn0) & bus.req0 & bus.out_ready;
    assign w_ack1  = (r_state == StOwn1) & bus.req1 & bus.out_ready;
    assign w_final = (r_cnt == LastBeat);

    // r_last == 1 means requester 1 was served most recently, so requester 0 wins a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req0 && (!bus.req1 || r_last)) begin
                        r_state <= StOwn0;
                        r_gnt0  <= 1'b1;
                        r_gnt1  <= 1'b0;
                        r_sel   <= 1'b0;
                        r_last  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else if (bus.req1) begin
                        r_state <= StOwn1;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b1;
                        r_sel   <= 1'b1;
                        r_last  <= 1'b1;
                        r_cnt   <= 8'd0;
                    end
                end
                StOwn0: begin
                    if (w_ack0 && w_final) begin
                        if (bus.req1) begin
                            r_state <= StOwn1;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b1;
                            r_sel   <= 1'b1;
                            r_last  <= 1'b1;
                        end
                        r_cnt <= 8'd0;
                    end else if (w_ack0) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (!bus.req0) begin
                        if (bus.req1) begin
                            r_state <= StOwn1;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b1;
                            r_sel   <= 1'b1;
                            r_last  <= 1'b1;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_state <= StIdle;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end
                end
                StOwn1: begin
                    if (w_ack1 && w_final) begin
                        if (bus.req0) begin
                            r_state <= StOwn0;
                            r_gnt0  <= 1'b1;
                            r_gnt1  <= 1'b0;
                            r_sel   <= 1'b0;
                            r_last  <= 1'b0;
                        end
                        r_cnt <= 8'd0;
                    end else if (w_ack1) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (!bus.req1) begin
                        if (bus.req0) begin
                            r_state <= StOwn0;
                            r_gnt0  <= 1'b1;
                            r_gnt1  <= 1'b0;
                            r_sel   <= 1'b0;
                            r_last  <= 1'b0;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_state <= StIdle;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.ack0      = w_ack0;
    assign bus.ack1      = w_ack1;
    assign bus.out_valid = ((r_state == StOwn0) & bus.req0) | ((r_state == StOwn1) & bus.req1);
    assign bus.out_data  = (bus.data0 & ~{DATA_W{r_sel}}) | (bus.data1 & {DATA_W{r_sel}});

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios with literal expectations plus a randomized run,
// every cycle compared against a grant/beat-count model of the arbitration rules.
module tb_mux2_rr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux2_rr_arbiter_if #(.DATA_W(DW)) bus ();

    mux2_rr_arbiter #(
        .DATA_W   (DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner -1 = nobody, beats = beats accepted in the current grant.
    int   m_owner;
    int   m_last;
    int   m_beats;
    logic m_sel;
    logic m_acked [2];

    function automatic logic mreq(int x);
        return (x == 1) ? bus.req1 : bus.req0;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_last     = 1;
        m_beats    = 0;
        m_sel      = 1'b0;
        m_acked[0] = 1'b0;
        m_acked[1] = 1'b0;
    endtask

    task automatic take(int y);
        m_owner = y;
        m_last  = y;
        m_beats = 0;
        m_sel   = (y == 1);
    endtask

    task automatic model_step();
        int x;
        int o;
        if (rst) begin
            model_reset();
            return;
        end
        m_acked[0] = 1'b0;
        m_acked[1] = 1'b0;
        if (m_owner < 0) begin
            if (bus.req0 && bus.req1) take(1 - m_last);
            else if (bus.req0) take(0);
            else if (bus.req1) take(1);
        end else begin
            x = m_owner;
            o = 1 - x;
            if (mreq(x) && bus.out_ready) begin
                m_acked[x] = 1'b1;
                m_beats++;
                if (m_beats == int'(MB)) begin
                    if (mreq(o)) take(o);
                    else m_beats = 0;
                end
            end else if (!mreq(x)) begin
                if (mreq(o)) take(o);
                else m_owner = -1;
            end
        end
    endtask

    function automatic logic [DW+5:0] exp_vec();
        logic g0, g1, v, a0, a1;
        logic [DW-1:0] od;
        g0 = (m_owner == 0);
        g1 = (m_owner == 1);
        v  = (m_owner >= 0) && mreq(m_owner);
        a0 = g0 && bus.req0 && bus.out_ready;
        a1 = g1 && bus.req1 && bus.out_ready;
        od = m_sel ? bus.data1 : bus.data0;
        return {g0, g1, m_sel, v, a0, a1, od};
    endfunction

    function automatic logic [DW+5:0] dut_vec();
        return {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.ack0, bus.ack1, bus.out_data};
    endfunction

    task automatic sample();
        @(negedge clk);
        check("model_outputs", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_inputs(logic r0, logic [DW-1:0] d0, logic r1, logic [DW-1:0] d1,
                              logic rdy);
        bus.req0      = r0;
        bus.data0     = d0;
        bus.req1      = r1;
        bus.data1     = d1;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        set_inputs(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (5) begin
            sample();
            check("reset_outs",
                  64'({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.ack0, bus.ack1}), 64'(0));
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic drive_random();
        for (int x = 0; x < 2; x++) begin
            logic r;
            logic [DW-1:0] d;
            r = mreq(x);
            d = (x == 1) ? bus.data1 : bus.data0;
            if (r && !m_acked[x]) begin
                if ($urandom_range(0, 9) == 0) r = 1'b0;
            end else begin
                r = ($urandom_range(0, 9) < 6);
                d = DW'($urandom);
            end
            if (x == 0) begin
                bus.req0  = r;
                bus.data0 = d;
            end else begin
                bus.req1  = r;
                bus.data1 = d;
            end
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        model_reset();
        set_inputs(1'b0, '0, 1'b0, '0, 1'b0);
        #1;

        // Single requester: one-cycle bubble, then a beat every cycle across burst boundaries.
        do_reset();
        set_inputs(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        sample();
        check("single_bubble", 64'({bus.gnt0, bus.out_valid}), 64'(0));
        advance();
        for (int i = 0; i < 10; i++) begin
            sample();
            check("single_beat", 64'({bus.gnt0, bus.ack0, bus.out_data}), 64'({2'b11, 8'hA5}));
            advance();
        end

        // Tie from reset: requester 0 first, bursts of MB alternate.
        do_reset();
        set_inputs(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        sample();
        check("tie_bubble", 64'(bus.out_valid), 64'(0));
        advance();
        for (int i = 0; i < 16; i++) begin
            logic es;
            es = ((i / 4) % 2) == 1;
            sample();
            check("tie_sel", 64'(bus.sel), 64'(es));
            check("tie_data", 64'(bus.out_data), es ? 64'h22 : 64'h11);
            check("tie_ack", 64'({bus.ack0, bus.ack1}), es ? 64'b01 : 64'b10);
            advance();
        end

        // Backpressure in OWN1 after two beats.
        do_reset();
        set_inputs(1'b0, 8'h00, 1'b1, 8'h5C, 1'b1);
        sample();
        advance();
        repeat (2) begin
            sample();
            check("bp_pre_ack", 64'(bus.ack1), 64'(1));
            advance();
        end
        bus.out_ready = 1'b0;
        repeat (3) begin
            sample();
            check("bp_stall", 64'({bus.gnt1, bus.out_valid, bus.ack1, bus.out_data}),
                  64'({3'b110, 8'h5C}));
            advance();
        end
        set_inputs(1'b1, 8'h3A, 1'b1, 8'h5C, 1'b1);
        repeat (2) begin
            sample();
            check("bp_post_ack", 64'({bus.ack1, bus.sel}), 64'(2'b11));
            advance();
        end
        sample();
        check("bp_rearb", 64'({bus.gnt0, bus.gnt1, bus.sel, bus.out_data}), 64'({3'b100, 8'h3A}));
        advance();

        // Early withdraw of owner 0 after two beats.
        do_reset();
        set_inputs(1'b1, 8'h77, 1'b1, 8'h99, 1'b1);
        sample();
        advance();
        repeat (2) begin
            sample();
            check("wd_ack0", 64'({bus.gnt0, bus.ack0}), 64'(2'b11));
            advance();
        end
        bus.req0 = 1'b0;
        sample();
        check("wd_drop", 64'({bus.gnt0, bus.ack0, bus.out_valid}), 64'(3'b100));
        advance();
        repeat (2) begin
            sample();
            check("wd_own1", 64'({bus.gnt1, bus.ack1, bus.ack0, bus.out_data}),
                  64'({3'b110, 8'h99}));
            advance();
        end

        // Async reset between edges during OWN1.
        do_reset();
        set_inputs(1'b0, 8'h0F, 1'b1, 8'hF0, 1'b1);
        sample();
        advance();
        sample();
        advance();
        bus.req0 = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_drop", 64'({bus.gnt1, bus.out_valid, bus.ack1}), 64'(0));
        sample();
        advance();
        rst = 1'b0;
        sample();
        check("arst_bubble", 64'(bus.out_valid), 64'(0));
        advance();
        sample();
        check("arst_first", 64'({bus.gnt0, bus.gnt1, bus.sel}), 64'(3'b100));
        advance();

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (rst) rst = 1'b0;
            drive_random();
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
            end
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2:1 bit-wise datapath mux.
- Two requesters each present a word plus a request. The block grants one owner at a time and drives the mux select.
- It presents the muxed word to a single sink with a valid/ready handshake.
- Burst length per grant is capped so neither requester can starve the other.

Parameters:
- DATA_W, 8, width of each requester word and of out_data.
- MAX_BURST, 4, maximum accepted beats per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a valid word on data0.
- data0  input  DATA_W  requester 0 word; held stable while req0=1 and ack0=0.
- req1  input  1  requester 1 has a valid word on data1.
- data1  input  DATA_W  requester 1 word; same stability rule.
- out_ready  input  1  sink can accept a beat this cycle.
- sel  output  1  mux select; 0 routes data0, 1 routes data1.
- gnt0  output  1  requester 0 owns the datapath (registered).
- gnt1  output  1  requester 1 owns the datapath (registered).
- out_valid  output  1  out_data carries a beat.
- out_data  output  DATA_W  muxed word.
- ack0  output  1  requester 0 beat accepted this cycle.
- ack1  output  1  requester 1 beat accepted this cycle.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0.
  - Internal last-served flag last=1, so requester 0 wins the first tie.
  - Internal beat counter cnt=0.
- Reset asserted mid-burst drops both grants at once. No ack is issued while rst=1.
- States:
  - IDLE: no owner.
  - OWN0: gnt0=1, sel=0.
  - OWN1: gnt1=1, sel=1.
  - gnt0/gnt1/sel are registered state outputs. gnt0 and gnt1 are never both 1.
- IDLE transitions:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - Both requesting -> the requester with index != last.
  - Neither -> stay IDLE.
- Grant latency: 1 cycle from the request seen in IDLE to the grant.
- On entering OWNx: last<=x, cnt<=0.
- sel holds its previous value in IDLE; it is never left undefined.
- Datapath (combinational from registered sel): out_data = (data0 & ~{sel}) | (data1 & {sel}), bit-wise across DATA_W.
- Handshake in OWNx:
  - out_valid = reqx.
  - ackx = reqx & out_ready. ack of the non-owner is always 0.
  - In IDLE: out_valid=0, ack0=ack1=0.
- Counter: cnt increments on each ack in OWNx. Width is 8 bits, and it never wraps because it is reset on release.
- Release conditions from OWNx (evaluated each cycle), with next state as follows:
  - reqx=0 (owner withdrew, no ack this cycle): other requesting -> OWN other; else -> IDLE.
  - ack with cnt==MAX_BURST-1 (final beat of the burst): other requesting -> OWN other; else -> re-enter OWNx with cnt<=0, no bubble cycle.
  - Otherwise stay in OWNx.
- Stall: out_ready=0 with reqx=1 holds state, cnt and sel; out_valid stays 1 and out_data stays stable.
- MAX_BURST=1 gives strict alternation whenever both requesters are active.
- Simultaneous final ack and owner deassert in the same cycle: the ack counts and the release follows the final-beat rule.
- Throughput: one beat per cycle while the owner requests and out_ready=1. There is a 1-cycle bubble only from IDLE to the first grant.

Test Plan:
- Reset then idle: rst pulse with req0=req1=0 for 5 cycles -> gnt0=gnt1=0, sel=0, out_valid=0, no acks.
- Single requester, DATA_W=8:
  - Stimulus: req0=1, data0=0xA5, out_ready=1.
  - Response: gnt0=1 next cycle; out_data=0xA5 and ack0=1 every cycle; after 4 acks it re-enters OWN0 with no gap.
- Tie and round-robin:
  - Stimulus: req0=req1=1 from reset, data0=0x11, data1=0x22, MAX_BURST=4.
  - Response: 4 beats of 0x11 (sel=0), then 4 beats of 0x22 (sel=1), then repeat; gnt0 and gnt1 are never high together.
- Backpressure: in OWN1 with cnt=2, hold out_ready=0 for 3 cycles -> out_valid=1, out_data=data1, ack1=0, cnt stays 2; release ready -> 2 more acks, then re-arbitrate.
- Early withdraw:
  - Stimulus: OWN0, req0 drops after 2 acks, req1=1.
  - Response: OWN1 next cycle; ack0 never asserts after the drop.
- Async reset mid-burst: assert rst between clock edges during OWN1 -> gnt1, out_valid and ack1 go to 0 before the next edge; after release with both requesting, requester 0 is granted first.
